// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: RV32 opcodes, funct3 codes and FSM states.
package ex_pkg;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] LUI    = 7'b0110111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/ex_div_iter.sv
// Unsigned restoring divider, one quotient bit per cycle; done pulses for one cycle
// after the XLEN-th iteration. abort drops the operation in progress.
module ex_div_iter #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    localparam int CW = $clog2(XLEN) + 1;

    logic [XLEN-1:0] q_reg;
    logic [XLEN-1:0] r_reg;
    logic [XLEN-1:0] d_reg;
    logic [CW-1:0]   cnt_reg;
    logic            busy_reg;
    logic            done_reg;
    logic [XLEN:0]   r_shift;
    logic [XLEN:0]   r_sub;

    // The dividend shifts out of q_reg into the partial remainder as quotient bits shift in.
    assign r_shift = {r_reg, q_reg[XLEN-1]};
    assign r_sub   = r_shift - {1'b0, d_reg};

    always_ff @(posedge clk) begin
        if (!rst) begin
            q_reg    <= '0;
            r_reg    <= '0;
            d_reg    <= '0;
            cnt_reg  <= '0;
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (abort) begin
                busy_reg <= 1'b0;
            end else if (start) begin
                q_reg    <= dividend;
                r_reg    <= '0;
                d_reg    <= divisor;
                cnt_reg  <= '0;
                busy_reg <= 1'b1;
            end else if (busy_reg) begin
                if (!r_sub[XLEN]) begin
                    r_reg <= r_sub[XLEN-1:0];
                    q_reg <= {q_reg[XLEN-2:0], 1'b1};
                end else begin
                    r_reg <= r_shift[XLEN-1:0];
                    q_reg <= {q_reg[XLEN-2:0], 1'b0};
                end
                cnt_reg <= cnt_reg + 1'b1;
                if (cnt_reg == CW'(XLEN - 1)) begin
                    busy_reg <= 1'b0;
                    done_reg <= 1'b1;
                end
            end
        end
    end

    assign busy      = busy_reg;
    assign done      = done_reg;
    assign quotient  = q_reg;
    assign remainder = r_reg;

endmodule

// File: rtl/ex_alu_mc.sv
// RV32 execute stage: single-cycle ALU and multiplier, iterative divide/remainder,
// valid/ready on both sides with a single output register.
module ex_alu_mc
    import ex_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter bit          M_EXT = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      t,
    input  logic [2:0]      st,
    input  logic            sst,
    input  logic            mx,
    input  logic [XLEN-1:0] n1,
    input  logic [XLEN-1:0] n2,
    input  logic [4:0]      wa,
    input  logic            we,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      wa_o,
    output logic            we_o,
    output logic [XLEN-1:0] wn_o
);

    localparam int SHW = $clog2(XLEN);

    logic [1:0]        state_reg;
    logic              out_valid_reg;
    logic [4:0]        wa_reg;
    logic              we_reg;
    logic [XLEN-1:0]   wn_reg;

    logic              dq_neg_reg;
    logic              dr_neg_reg;
    logic              drem_reg;
    logic [4:0]        dwa_reg;
    logic              dwe_reg;

    logic              accept;
    logic              is_div;
    logic              div_signed;
    logic              div_rem;
    logic              alu_we;
    logic [XLEN-1:0]   alu_res;

    logic              a_sx;
    logic              b_sx;
    logic [2*XLEN-1:0] a_ext;
    logic [2*XLEN-1:0] b_ext;
    logic [2*XLEN-1:0] prod;
    logic [SHW-1:0]    shamt;
    logic [XLEN-1:0]   sra_res;

    logic              n1_neg;
    logic              n2_neg;
    logic [XLEN-1:0]   dvd;
    logic [XLEN-1:0]   dvs;
    logic              div_busy;
    logic              div_done;
    logic [XLEN-1:0]   div_q;
    logic [XLEN-1:0]   div_r;
    logic [XLEN-1:0]   q_fix;
    logic [XLEN-1:0]   r_fix;

    assign in_ready = (state_reg == IDLE) & !div_busy & (!out_valid_reg | out_ready) & !flush;
    assign accept   = in_valid & in_ready;

    // One 2*XLEN multiplier serves all four variants via selective sign extension.
    assign a_sx  = (st == F3_MULH) | (st == F3_MULHSU);
    assign b_sx  = (st == F3_MULH);
    assign a_ext = {{XLEN{a_sx & n1[XLEN-1]}}, n1};
    assign b_ext = {{XLEN{b_sx & n2[XLEN-1]}}, n2};
    assign prod  = a_ext * b_ext;

    assign shamt   = n2[SHW-1:0];
    assign sra_res = $signed(n1) >>> shamt;

    always_comb begin
        alu_res    = '0;
        alu_we     = we;
        is_div     = 1'b0;
        div_signed = 1'b0;
        div_rem    = 1'b0;
        case (t)
            OP_IMM, OP: begin
                if ((t == OP) && mx) begin
                    if (M_EXT) begin
                        case (st)
                            F3_MUL:                       alu_res = prod[XLEN-1:0];
                            F3_MULH, F3_MULHSU, F3_MULHU: alu_res = prod[2*XLEN-1:XLEN];
                            F3_DIV:  begin is_div = 1'b1; div_signed = 1'b1; end
                            F3_DIVU: begin is_div = 1'b1; end
                            F3_REM:  begin is_div = 1'b1; div_signed = 1'b1; div_rem = 1'b1; end
                            F3_REMU: begin is_div = 1'b1; div_rem = 1'b1; end
                            default: alu_res = '0;
                        endcase
                    end else begin
                        alu_we = 1'b0;
                    end
                end else begin
                    case (st)
                        F3_ADD:  alu_res = ((t == OP) && sst) ? (n1 - n2) : (n1 + n2);
                        F3_SLL:  alu_res = n1 << shamt;
                        F3_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(n1) < $signed(n2))};
                        F3_SLTU: alu_res = {{(XLEN-1){1'b0}}, (n1 < n2)};
                        F3_XOR:  alu_res = n1 ^ n2;
                        F3_SR:   alu_res = sst ? sra_res : (n1 >> shamt);
                        F3_OR:   alu_res = n1 | n2;
                        F3_AND:  alu_res = n1 & n2;
                        default: alu_res = '0;
                    endcase
                end
            end
            LUI:     alu_res = n2;
            default: alu_we  = 1'b0;
        endcase
    end

    // The divider works on magnitudes; signs are restored when the result is loaded.
    assign n1_neg = div_signed & n1[XLEN-1];
    assign n2_neg = div_signed & n2[XLEN-1];
    assign dvd    = n1_neg ? -n1 : n1;
    assign dvs    = n2_neg ? -n2 : n2;

    ex_div_iter #(
        .XLEN(XLEN)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (accept & is_div),
        .abort    (flush),
        .dividend (dvd),
        .divisor  (dvs),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_q),
        .remainder(div_r)
    );

    // A zero divisor leaves an all-ones quotient and the dividend magnitude as remainder,
    // so suppressing the quotient negation yields q=-1, r=n1 without a special path.
    assign q_fix = dq_neg_reg ? -div_q : div_q;
    assign r_fix = dr_neg_reg ? -div_r : div_r;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            wa_reg        <= '0;
            we_reg        <= 1'b0;
            wn_reg        <= '0;
            dq_neg_reg    <= 1'b0;
            dr_neg_reg    <= 1'b0;
            drem_reg      <= 1'b0;
            dwa_reg       <= '0;
            dwe_reg       <= 1'b0;
        end else if (flush) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
        end else begin
            if (out_valid_reg && out_ready) begin
                out_valid_reg <= 1'b0;
            end
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        if (is_div) begin
                            state_reg  <= BUSY;
                            dq_neg_reg <= (n1_neg ^ n2_neg) & (n2 != '0);
                            dr_neg_reg <= n1_neg;
                            drem_reg   <= div_rem;
                            dwa_reg    <= wa;
                            dwe_reg    <= we;
                        end else begin
                            out_valid_reg <= 1'b1;
                            wa_reg        <= wa;
                            we_reg        <= alu_we;
                            wn_reg        <= alu_res;
                        end
                    end
                end
                BUSY: begin
                    if (div_done) begin
                        state_reg     <= DONE;
                        out_valid_reg <= 1'b1;
                        wa_reg        <= dwa_reg;
                        we_reg        <= dwe_reg;
                        wn_reg        <= drem_reg ? r_fix : q_fix;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign out_valid = out_valid_reg;
    assign wa_o      = wa_reg;
    assign we_o      = we_reg;
    assign wn_o      = wn_reg;

endmodule

// File: tb/tb_ex_alu_mc.sv
// Scoreboard bench for ex_alu_mc: directed corner cases then randomized traffic with backpressure.
module tb_ex_alu_mc;

    localparam logic [6:0] T_OPIMM = 7'b0010011;
    localparam logic [6:0] T_OP    = 7'b0110011;
    localparam logic [6:0] T_LUI   = 7'b0110111;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, sst, mx, we, out_valid, out_ready, we_o;
    logic [6:0]  t;
    logic [2:0]  st;
    logic [31:0] n1, n2, wn_o;
    logic [4:0]  wa, wa_o;

    always #5 clk = ~clk;

    ex_alu_mc #(.XLEN(32), .M_EXT(1'b1)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .t(t), .st(st), .sst(sst), .mx(mx), .n1(n1), .n2(n2), .wa(wa), .we(we),
        .out_valid(out_valid), .out_ready(out_ready), .wa_o(wa_o), .we_o(we_o), .wn_o(wn_o)
    );

    typedef struct {
        logic [4:0]  wa;
        logic        we;
        logic [31:0] wn;
        int          exp_cyc;
    } exp_t;

    exp_t        sbq[$];
    int          compared = 0;
    int          mismatched = 0;
    int          cyc = 0;
    bit          bp_en = 0;
    bit          seen = 0;
    bit          hold_chk = 0;
    logic [37:0] held;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference behaviour from the ISA definition, using native integer arithmetic.
    function automatic logic [32:0] model(input logic [6:0] ti, input logic [2:0] f3,
                                          input logic s7, input logic m7,
                                          input logic [31:0] a, input logic [31:0] b,
                                          input logic wen);
        logic [31:0] r;
        logic [63:0] p;
        int          sa, sb;
        bit          ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        r   = '0;
        if (ti == T_LUI) return {wen, b};
        if (ti != T_OPIMM && ti != T_OP) return 33'd0;
        if (ti == T_OP && m7) begin
            case (f3)
                3'd0: begin p = {32'd0, a} * {32'd0, b}; r = p[31:0]; end
                3'd1: begin p = longint'(sa) * longint'(sb); r = p[63:32]; end
                3'd2: begin p = longint'(sa) * longint'({32'd0, b}); r = p[63:32]; end
                3'd3: begin p = {32'd0, a} * {32'd0, b}; r = p[63:32]; end
                3'd4: r = (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(sa / sb));
                3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
                3'd6: r = (b == 0) ? a : (ovf ? 32'd0 : 32'(sa % sb));
                default: r = (b == 0) ? a : a % b;
            endcase
        end else begin
            case (f3)
                3'd0: r = (ti == T_OP && s7) ? a - b : a + b;
                3'd1: r = a << b[4:0];
                3'd2: r = (sa < sb) ? 32'd1 : 32'd0;
                3'd3: r = (a < b) ? 32'd1 : 32'd0;
                3'd4: r = a ^ b;
                3'd5: r = s7 ? 32'(sa >>> b[4:0]) : a >> b[4:0];
                3'd6: r = a | b;
                default: r = a & b;
            endcase
        end
        return {wen, r};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (bp_en) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic issue(input logic [6:0] ti, input logic [2:0] f3, input logic s7,
                         input logic m7, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] w, input logic wen);
        exp_t        e;
        logic [32:0] m;
        bit          got;
        got = 0;
        t = ti; st = f3; sst = s7; mx = m7; n1 = a; n2 = b; wa = w; we = wen;
        in_valid = 1'b1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            got = in_ready;
            tick();
            if (got) break;
        end
        in_valid = 1'b0;
        if (!got) begin
            check("issue_accept_timeout", 64'(got), 64'd1);
        end else begin
            m         = model(ti, f3, s7, m7, a, b, wen);
            e.wa      = w;
            e.we      = m[32];
            e.wn      = m[31:0];
            e.exp_cyc = cyc + ((ti == T_OP && m7 && f3[2]) ? 33 : 0);
            sbq.push_back(e);
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 600; k++) begin
            if (sbq.size() == 0) break;
            tick();
        end
        check("drain_empty", 64'(sbq.size()), 64'd0);
        tick();
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 9))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    // Monitor: compares each presented result against the head of the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            if (out_valid) begin
                if (sbq.size() == 0) begin
                    check("unexpected_result", 64'd1, 64'd0);
                end else begin
                    if (!seen) begin
                        check("latency_cycle", 64'(cyc), 64'(sbq[0].exp_cyc));
                        seen = 1;
                    end
                    if (hold_chk) check("held_stable", 64'({wa_o, we_o, wn_o}), 64'(held));
                    if (out_ready) begin
                        check("wa_o", 64'(wa_o), 64'(sbq[0].wa));
                        check("we_o", 64'(we_o), 64'(sbq[0].we));
                        check("wn_o", 64'(wn_o), 64'(sbq[0].wn));
                        $display("[cyc %0d] result wa=%0d we=%0b wn=0x%08h", cyc, wa_o, we_o, wn_o);
                        void'(sbq.pop_front());
                        seen     = 0;
                        hold_chk = 0;
                    end else begin
                        held     = {wa_o, we_o, wn_o};
                        hold_chk = 1;
                    end
                end
            end else begin
                hold_chk = 0;
            end
        end
    end

    initial begin
        int          bad;
        int          kind;
        logic [6:0]  rt;
        logic [2:0]  rf3;
        logic        rs7, rm7;
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        t = '0; st = '0; sst = 1'b0; mx = 1'b0; n1 = '0; n2 = '0; wa = '0; we = 1'b0;

        tick(); tick();
        @(negedge clk);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_wa_o", 64'(wa_o), 64'd0);
        check("reset_we_o", 64'(we_o), 64'd0);
        check("reset_wn_o", 64'(wn_o), 64'd0);
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("idle_in_ready", 64'(in_ready), 64'd1);
        tick();

        issue(T_OPIMM, 3'd0, 1'b0, 1'b0, 32'd5, 32'hFFFF_FFFD, 5'd3, 1'b1);
        issue(T_OP, 3'd2, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 5'd4, 1'b1);
        issue(T_OP, 3'd3, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 5'd5, 1'b1);
        issue(T_OP, 3'd5, 1'b1, 1'b0, 32'h8000_0000, 32'd4, 5'd6, 1'b1);
        issue(T_OP, 3'd5, 1'b0, 1'b0, 32'h8000_0000, 32'd4, 5'd7, 1'b1);
        issue(T_LUI, 3'd0, 1'b0, 1'b0, 32'd0, 32'hABCD_E000, 5'd8, 1'b1);
        issue(7'b1111111, 3'd0, 1'b0, 1'b0, 32'd1, 32'd2, 5'd9, 1'b1);

        issue(T_OP, 3'd4, 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 5'd10, 1'b1);
        bad = 0;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            if (in_ready) bad++;
            tick();
        end
        check("div_in_ready_low", 64'(bad), 64'd0);
        issue(T_OP, 3'd6, 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 5'd11, 1'b1);
        issue(T_OP, 3'd5, 1'b0, 1'b1, 32'd5, 32'd0, 5'd12, 1'b1);
        issue(T_OP, 3'd4, 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd0, 5'd13, 1'b1);
        issue(T_OP, 3'd4, 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 1'b1);
        issue(T_OP, 3'd6, 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 1'b1);
        issue(T_OP, 3'd1, 1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, 5'd16, 1'b1);
        drain();

        // Backpressure: result held for 5 cycles while a second op waits.
        issue(T_OP, 3'd0, 1'b0, 1'b0, 32'd1, 32'd2, 5'd17, 1'b1);
        out_ready = 1'b0;
        t = T_OP; st = 3'd0; n1 = 32'd7; n2 = 32'd8; wa = 5'd18; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_in_ready", 64'(in_ready), 64'd0);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        issue(T_OP, 3'd0, 1'b1, 1'b0, 32'd7, 32'd8, 5'd18, 1'b1);
        drain();

        // Flush during a divide, with a competing op offered in the flush cycle.
        issue(T_OP, 3'd4, 1'b0, 1'b1, 32'd100, 32'd7, 5'd19, 1'b1);
        for (int k = 0; k < 10; k++) tick();
        flush = 1'b1;
        t = T_OP; st = 3'd0; mx = 1'b0; n1 = 32'd3; n2 = 32'd4; in_valid = 1'b1;
        @(negedge clk);
        check("flush_in_ready", 64'(in_ready), 64'd0);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        void'(sbq.pop_back());
        @(negedge clk);
        check("post_flush_in_ready", 64'(in_ready), 64'd1);
        check("post_flush_out_valid", 64'(out_valid), 64'd0);
        for (int k = 0; k < 40; k++) tick();

        // Reset during a divide.
        issue(T_OP, 3'd6, 1'b0, 1'b1, 32'd100, 32'd7, 5'd20, 1'b1);
        for (int k = 0; k < 10; k++) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        void'(sbq.pop_back());
        @(negedge clk);
        check("rst_div_out_valid", 64'(out_valid), 64'd0);
        check("rst_div_wa_o", 64'(wa_o), 64'd0);
        check("rst_div_wn_o", 64'(wn_o), 64'd0);
        check("rst_div_in_ready", 64'(in_ready), 64'd1);
        for (int k = 0; k < 40; k++) tick();

        bp_en = 1;
        for (int i = 0; i < 150; i++) begin
            kind = $urandom_range(0, 9);
            rf3  = 3'($urandom_range(0, 7));
            rs7  = 1'($urandom_range(0, 1));
            rm7  = 1'($urandom_range(0, 1));
            case (kind)
                0, 1, 2: rt = T_OPIMM;
                3, 4: begin
                    rt = T_OP; rm7 = 1'b0;
                    if (rf3 != 3'd0 && rf3 != 3'd5) rs7 = 1'b0;
                end
                5, 6: begin rt = T_OP; rm7 = 1'b1; rf3[2] = 1'b0; end
                7:    begin rt = T_OP; rm7 = 1'b1; rf3[2] = 1'b1; end
                8:    rt = T_LUI;
                default: begin
                    rt = 7'($urandom_range(0, 127));
                    if (rt == T_OP || rt == T_OPIMM || rt == T_LUI) rt = 7'b0000011;
                end
            endcase
            issue(rt, rf3, rs7, rm7, rnd_val(), rnd_val(), 5'($urandom_range(0, 31)),
                  1'($urandom_range(0, 7) != 0));
            if ($urandom_range(0, 3) == 0) tick();
        end
        drain();
        bp_en = 0;
        out_ready = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
